// File: rtl/gpu_prefetch.sv
// Instruction prefetch sequencer: issues longword fetches to the local memory
// controller, buffers returns in an in-order queue and feeds decode with
// 16-bit opcodes. A jump flushes the queue and drops fetches still in flight.
module gpu_prefetch #(
  parameter int QDEPTH = 4,
  parameter int DW     = 32
) (
  input  logic          sys_clk,
  input  logic          reset_n,
  input  logic          go,
  input  logic          jump,
  input  logic [23:0]   jump_addr,
  input  logic          big_instr,
  output logic          progreq,
  output logic [21:0]   progaddr,
  input  logic          progack,
  output logic          pabort,
  input  logic          prog_dv,
  input  logic [DW-1:0] prog_data,
  output logic [15:0]   instr,
  output logic          instr_valid,
  input  logic          instr_ack
);

  localparam int AW = $clog2(QDEPTH);
  // Counters get headroom: after a jump, fetches awaiting discard sit in
  // outst on top of a fresh window of up to QDEPTH live fetches.
  localparam int CW = AW + 3;

  logic [DW-1:0] mem [QDEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt, outst, discard, pending, outst_nxt;
  logic [21:0]   fetch_addr, fetch_nxt;
  logic          hsel, ack, dv, wr_en, adv, pop, lo_half;
  logic [DW-1:0] head;
  logic          unused_ok;

  assign unused_ok  = jump_addr[0];

  // progack only counts while a request is actually presented; a return with
  // nothing outstanding (e.g. straggler after reset) is ignored.
  assign ack        = progreq & progack;
  assign dv         = prog_dv & (outst != '0);
  assign wr_en      = dv & (discard == '0) & ~jump;
  assign adv        = instr_ack & instr_valid & ~jump;
  assign pop        = adv & hsel;
  assign outst_nxt  = outst + CW'(ack) - CW'(dv);
  assign fetch_nxt  = fetch_addr + 22'(ack);

  // Live words: buffered, in flight (minus those to be dropped) and the held request.
  assign pending    = cnt + outst - discard + CW'(progreq);

  assign instr_valid = (cnt != '0);
  assign head        = mem[rd];
  // Low half is selected when hsel matches the halfword order flag.
  assign lo_half     = (hsel == big_instr);

  // Opcode mux; forced to zero while the queue is empty.
  always_comb begin
    instr = '0;
    if (instr_valid) instr = lo_half ? head[15:0] : head[DW-1:16];
  end

  // Queue storage; flushes only move pointers, so no reset is needed here.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr] <= prog_data;
  end

  // Fetch issue, in-flight accounting, queue pointers and halfword select.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      progreq    <= 1'b0;
      progaddr   <= '0;
      pabort     <= 1'b0;
      fetch_addr <= '0;
      outst      <= '0;
      discard    <= '0;
      cnt        <= '0;
      rd         <= '0;
      wr         <= '0;
      hsel       <= 1'b0;
    end else begin
      outst <= outst_nxt;
      if (jump) begin
        // Everything in flight after this edge is stale.
        discard    <= outst_nxt;
        fetch_addr <= jump_addr[23:2];
        progreq    <= 1'b0;
        pabort     <= progreq & ~progack;
        cnt        <= '0;
        rd         <= '0;
        wr         <= '0;
        hsel       <= jump_addr[1];
      end else begin
        pabort     <= 1'b0;
        fetch_addr <= fetch_nxt;
        if (dv && discard != '0) discard <= discard - CW'(1);
        // A presented request holds with its address until accepted.
        if (!(progreq && !progack)) begin
          progreq  <= go && (pending < CW'(QDEPTH));
          progaddr <= fetch_nxt;
        end
        if (wr_en) wr <= wr + AW'(1);
        if (pop)   rd <= rd + AW'(1);
        cnt <= cnt + CW'(wr_en) - CW'(pop);
        if (adv) hsel <= ~hsel;
      end
    end
  end

endmodule

// File: tb/tb_gpu_prefetch.sv
// Directed bench for gpu_prefetch: a small memory-controller model acks
// requests and returns data one cycle later; opcodes consumed by decode are
// logged and compared against hand-computed sequences.
module tb_gpu_prefetch;
  localparam int QDEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        reset_n, go, jump, big_instr, progreq, progack, pabort;
  logic        prog_dv, instr_valid, instr_ack;
  logic [23:0] jump_addr;
  logic [21:0] progaddr;
  logic [31:0] prog_data;
  logic [15:0] instr;

  int          n_chk = 0, n_fail = 0;
  bit          ack_auto, dv_auto, iack_auto, data_mode;
  logic [31:0] const_data;
  logic [21:0] rq[$];
  logic [15:0] ops[$];
  int          ack_cnt, full_hits;

  always #5 sys_clk = ~sys_clk;

  gpu_prefetch #(.QDEPTH(QDEPTH), .DW(32)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .go(go), .jump(jump),
    .jump_addr(jump_addr), .big_instr(big_instr), .progreq(progreq),
    .progaddr(progaddr), .progack(progack), .pabort(pabort),
    .prog_dv(prog_dv), .prog_data(prog_data), .instr(instr),
    .instr_valid(instr_valid), .instr_ack(instr_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [21:0] a);
    return data_mode ? {8'hA5, a[7:0], 8'h5A, a[7:0]} : const_data;
  endfunction

  function automatic logic [31:0] opat(input int i);
    return (ops.size() > i) ? {16'h0, ops[i]} : 32'hBAD0_0000;
  endfunction

  // One clock: sample before the edge, then drive the next cycle's inputs.
  task automatic step();
    logic        acked;
    logic [21:0] aa;
    acked = progreq & progack;
    aa    = progaddr;
    if (instr_valid === 1'b1 && instr_ack && !jump) ops.push_back(instr);
    if (prog_dv && dut.outst != 0 && dut.discard == 0 && dut.cnt == QDEPTH) full_hits++;
    @(posedge sys_clk);
    #1;
    if (acked) begin
      rq.push_back(aa);
      ack_cnt++;
    end
    jump    = 1'b0;
    progack = ack_auto ? progreq : 1'b0;
    if (dv_auto && rq.size() != 0) begin
      prog_dv   = 1'b1;
      prog_data = mdata(rq.pop_front());
    end else begin
      prog_dv   = 1'b0;
      prog_data = '0;
    end
    instr_ack = iack_auto & instr_valid;
  endtask

  // Reset while draining any returns the model still owes (DUT must ignore them).
  task automatic do_reset();
    reset_n = 1'b0; progack = 1'b0; ack_auto = 0; dv_auto = 1; iack_auto = 0;
    instr_ack = 1'b0; go = 1'b0; jump = 1'b0;
    for (int i = 0; i < 12; i++) step();
    reset_n = 1'b1;
    rq.delete();
    ops.delete();
  endtask

  initial begin
    reset_n = 0; go = 0; jump = 0; jump_addr = '0; big_instr = 1; progack = 0;
    prog_dv = 0; prog_data = '0; instr_ack = 0; ack_auto = 0; dv_auto = 0;
    iack_auto = 0; data_mode = 0; const_data = '0; ack_cnt = 0; full_hits = 0;

    // Reset values
    do_reset();
    chk("rst_progreq", {31'h0, progreq}, 0);
    chk("rst_progaddr", {10'h0, progaddr}, 0);
    chk("rst_pabort", {31'h0, pabort}, 0);
    chk("rst_valid", {31'h0, instr_valid}, 0);
    chk("rst_instr", {16'h0, instr}, 0);

    // Straggler return with nothing outstanding is ignored
    prog_dv = 1'b1; prog_data = 32'hDEADBEEF;
    step();
    chk("late_dv", {31'h0, instr_valid}, 0);

    // Basic streaming from 0xF03000, big-endian halfwords
    go = 1; big_instr = 1; const_data = 32'h12345678; data_mode = 0;
    ack_auto = 1; dv_auto = 1; iack_auto = 1;
    jump = 1; jump_addr = 24'hF03000; ops.delete();
    step(); chk("jmp_n1_req", {31'h0, progreq}, 0);
    step(); chk("jmp_n2_req", {31'h0, progreq}, 1);
    chk("jmp_n2_addr", {10'h0, progaddr}, 32'h3C0C00);
    step(); chk("seq_addr1", {10'h0, progaddr}, 32'h3C0C01);
    step(); chk("dv_valid", {31'h0, instr_valid}, 1);
    chk("first_instr", {16'h0, instr}, 32'h1234);
    step(); chk("second_instr", {16'h0, instr}, 32'h5678);
    repeat (8) step();
    chk("seq_op0", opat(0), 32'h1234);
    chk("seq_op1", opat(1), 32'h5678);
    chk("seq_op2", opat(2), 32'h1234);
    chk("seq_op3", opat(3), 32'h5678);

    // Reset mid-operation, then stall decode: exactly QDEPTH fetches
    do_reset();
    chk("midrst_req", {31'h0, progreq}, 0);
    chk("midrst_valid", {31'h0, instr_valid}, 0);
    go = 1; ack_auto = 1; dv_auto = 1; iack_auto = 0; data_mode = 1; big_instr = 1;
    ack_cnt = 0; jump = 1; jump_addr = 24'h000100;
    repeat (20) step();
    chk("stall_acks", ack_cnt, 4);
    chk("stall_req", {31'h0, progreq}, 0);
    chk("stall_instr", {16'h0, instr}, 32'hA540);
    instr_ack = 1; step();
    chk("stall_lo", {16'h0, instr}, 32'h5A40);
    instr_ack = 1; step();
    chk("pop_head", {16'h0, instr}, 32'hA541);
    repeat (8) step();
    chk("restart_acks", ack_cnt, 5);
    chk("restart_hold", {16'h0, instr}, 32'hA541);

    // Jump with two fetches in flight and one request pending
    do_reset();
    go = 1; ack_auto = 0; dv_auto = 0; iack_auto = 1; data_mode = 1; big_instr = 1;
    jump = 1; jump_addr = 24'h000200;
    step(); step();
    chk("ab_addr0", {10'h0, progaddr}, 32'h80);
    progack = 1; step();
    progack = 1; step();
    chk("ab_pend", {31'h0, progreq}, 1);
    chk("ab_addr2", {10'h0, progaddr}, 32'h82);
    jump = 1; jump_addr = 24'h000300; ops.delete();
    step();
    chk("pabort_on", {31'h0, pabort}, 1);
    chk("ab_discard", 32'(dut.discard), 2);
    chk("ab_req_low", {31'h0, progreq}, 0);
    step();
    chk("pabort_off", {31'h0, pabort}, 0);
    chk("ab_req_high", {31'h0, progreq}, 1);
    chk("ab_newaddr", {10'h0, progaddr}, 32'hC0);
    ack_auto = 1; dv_auto = 1; progack = 1;
    repeat (10) step();
    chk("ab_op0", opat(0), 32'hA5C0);
    chk("ab_op1", opat(1), 32'h5AC0);

    // Jump to an odd halfword: low half of first longword, then next longword
    data_mode = 0; const_data = 32'hAAAABBBB; big_instr = 1;
    jump = 1; jump_addr = 24'hF03002; ops.delete();
    repeat (12) step();
    chk("odd_op0", opat(0), 32'hBBBB);
    chk("odd_op1", opat(1), 32'hAAAA);
    chk("odd_op2", opat(2), 32'hBBBB);

    // Little halfword order
    big_instr = 0; const_data = 32'h11112222;
    jump = 1; jump_addr = 24'h000400; ops.delete();
    repeat (12) step();
    chk("le_op0", opat(0), 32'h2222);
    chk("le_op1", opat(1), 32'h1111);
    chk("le_op2", opat(2), 32'h2222);

    // Jump coincident with progack and prog_dv
    do_reset();
    go = 1; ack_auto = 0; dv_auto = 0; iack_auto = 1; data_mode = 1; big_instr = 1;
    jump = 1; jump_addr = 24'h000500;
    step(); step();
    progack = 1; step();
    progack = 1; step();
    chk("co_outst", 32'(dut.outst), 2);
    progack = 1; prog_dv = 1; prog_data = mdata(rq.pop_front());
    jump = 1; jump_addr = 24'h000600; ops.delete();
    step();
    chk("co_discard", 32'(dut.discard), 2);
    chk("co_empty", {31'h0, instr_valid}, 0);
    chk("co_pabort", {31'h0, pabort}, 0);
    ack_auto = 1; dv_auto = 1;
    repeat (12) step();
    chk("co_op0", opat(0), 32'hA580);
    chk("co_op1", opat(1), 32'h5A80);

    chk("no_full_dv", full_hits, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
